panel_arbiter: RTL and testbench

PANEL_ARBITER -- requirements
Module: panel_arbiter

---
 rtl/panel_arbiter_if.sv | 35 +++
 rtl/panel_arbiter.sv | 145 ++++++++++++++
 tb/tb_panel_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/panel_arbiter_if.sv
// panel_arbiter_if
// Bundles the frame sources, the scanner pulse and the display-side outputs
// of the panel arbiter.
//   live_frame/live_valid : live CPU snapshot and its one-cycle strobe
//   mon_req               : monitor overlay level request for ownership
//   mon_frame/mon_valid   : monitor overlay frame and its one-cycle strobe
//   scan_wrap             : scanner pulse at the end of digit 8
//   mon_gnt               : monitor owns the display
//   disp_frame/disp_valid : committed frame and its one-cycle commit pulse
//   owner                 : current source (0 live, 1 monitor)
// master = frame/scan producer side, slave = arbiter side.
interface panel_arbiter_if #(
  parameter int FRAME_W = 101
);
  logic [FRAME_W-1:0] live_frame;
  logic               live_valid;
  logic               mon_req;
  logic [FRAME_W-1:0] mon_frame;
  logic               mon_valid;
  logic               scan_wrap;
  logic               mon_gnt;
  logic [FRAME_W-1:0] disp_frame;
  logic               disp_valid;
  logic               owner;

  modport master (
    output live_frame, live_valid, mon_req, mon_frame, mon_valid, scan_wrap,
    input  mon_gnt, disp_frame, disp_valid, owner
  );

  modport slave (
    input  live_frame, live_valid, mon_req, mon_frame, mon_valid, scan_wrap,
    output mon_gnt, disp_frame, disp_valid, owner
  );
endinterface

// File: rtl/panel_arbiter.sv
// panel_arbiter
// Arbitrates display ownership between the live CPU snapshot and the monitor
// overlay. The owner's frames are captured into a one-deep pending buffer and
// committed to the display only on a scanner wrap, no more often than every
// MIN_HOLD cycles. Ownership handovers pass through a switch state that waits
// for a scanner wrap so that a display scan never mixes sources.
// Ports:
//   clk : sole clock
//   rst : asynchronous active-high reset
//   bus : panel_arbiter_if.slave (frame inputs, scan_wrap, display outputs)
module panel_arbiter #(
  parameter int FRAME_W     = 101,
  parameter int MIN_HOLD    = 1000,
  parameter int MON_TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  panel_arbiter_if.slave   bus
);

  localparam int HOLD_W = $clog2(MIN_HOLD + 1);

  typedef enum logic [1:0] {
    LIVE        = 2'd0,
    MON_SWITCH  = 2'd1,
    MON         = 2'd2,
    LIVE_SWITCH = 2'd3
  } state_t;

  state_t             state_reg;
  logic [FRAME_W-1:0] pend_reg;
  logic               pend_full_reg;
  logic               lockout_reg;
  logic [19:0]        idle_reg;
  logic [HOLD_W-1:0]  hold_reg;
  logic               owner_reg;
  logic               gnt_reg;
  logic [FRAME_W-1:0] disp_frame_reg;
  logic               disp_valid_reg;

  logic hold_sat;
  logic commit_ok;
  logic idle_expired;

  assign hold_sat     = (hold_reg == HOLD_W'(MIN_HOLD));
  assign commit_ok    = bus.scan_wrap && pend_full_reg && hold_sat;
  assign idle_expired = (idle_reg == 20'(MON_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= LIVE;
      pend_reg       <= '0;
      pend_full_reg  <= 1'b0;
      lockout_reg    <= 1'b0;
      idle_reg       <= '0;
      // Saturated at reset so the very first frame commits without waiting.
      hold_reg       <= HOLD_W'(MIN_HOLD);
      owner_reg      <= 1'b0;
      gnt_reg        <= 1'b0;
      disp_frame_reg <= '0;
      disp_valid_reg <= 1'b0;
    end else begin
      disp_valid_reg <= 1'b0;
      if (!hold_sat)
        hold_reg <= hold_reg + 1'b1;
      if (!bus.mon_req)
        lockout_reg <= 1'b0;

      case (state_reg)
        LIVE: begin
          if (bus.mon_req && !lockout_reg) begin
            // Handover wins over any commit or capture this cycle; the
            // pending live frame is flushed on the way out.
            state_reg     <= MON_SWITCH;
            pend_full_reg <= 1'b0;
          end else begin
            if (commit_ok) begin
              disp_frame_reg <= pend_reg;
              disp_valid_reg <= 1'b1;
              hold_reg       <= '0;
              pend_full_reg  <= 1'b0;
            end
            // Placed after the commit so a coinciding strobe refills the buffer.
            if (bus.live_valid) begin
              pend_reg      <= bus.live_frame;
              pend_full_reg <= 1'b1;
            end
          end
        end

        MON_SWITCH: begin
          if (!bus.mon_req) begin
            state_reg <= LIVE;
          end else if (bus.scan_wrap) begin
            state_reg <= MON;
            owner_reg <= 1'b1;
            gnt_reg   <= 1'b1;
            idle_reg  <= '0;
          end
        end

        MON: begin
          if (!bus.mon_req || idle_expired) begin
            state_reg     <= LIVE_SWITCH;
            gnt_reg       <= 1'b0;
            pend_full_reg <= 1'b0;
            // A still-requesting monitor that timed out is locked out until it
            // drops its request.
            if (bus.mon_req)
              lockout_reg <= 1'b1;
          end else begin
            if (commit_ok) begin
              disp_frame_reg <= pend_reg;
              disp_valid_reg <= 1'b1;
              hold_reg       <= '0;
              pend_full_reg  <= 1'b0;
            end
            if (bus.mon_valid) begin
              pend_reg      <= bus.mon_frame;
              pend_full_reg <= 1'b1;
              idle_reg      <= '0;
            end else if (!idle_expired) begin
              idle_reg <= idle_reg + 20'd1;
            end
          end
        end

        LIVE_SWITCH: begin
          if (bus.scan_wrap) begin
            state_reg <= LIVE;
            owner_reg <= 1'b0;
          end
        end

        default: state_reg <= LIVE;
      endcase
    end
  end

  assign bus.mon_gnt    = gnt_reg;
  assign bus.owner      = owner_reg;
  assign bus.disp_frame = disp_frame_reg;
  assign bus.disp_valid = disp_valid_reg;

endmodule

// File: tb/tb_panel_arbiter.sv
// tb_panel_arbiter
// Directed stimulus for panel_arbiter. Expected commits are pushed into a
// queue when stimulus is issued; a monitor pops one entry per disp_valid.
module tb_panel_arbiter;
  localparam int FRAME_W     = 101;
  localparam int MIN_HOLD    = 1000;
  localparam int MON_TIMEOUT = 100;

  typedef struct {
    logic [FRAME_W-1:0] frame;
    logic               owner;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  panel_arbiter_if #(.FRAME_W(FRAME_W)) pif();

  panel_arbiter #(
    .FRAME_W(FRAME_W),
    .MIN_HOLD(MIN_HOLD),
    .MON_TIMEOUT(MON_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [FRAME_W-1:0] f, input logic o);
    exp_t e;
    e.frame = f;
    e.owner = o;
    exp_q.push_back(e);
  endtask

  task automatic pulse_live(input logic [FRAME_W-1:0] f);
    pif.live_frame = f;
    pif.live_valid = 1'b1;
    tick(1);
    pif.live_valid = 1'b0;
  endtask

  task automatic pulse_mon(input logic [FRAME_W-1:0] f);
    pif.mon_frame = f;
    pif.mon_valid = 1'b1;
    tick(1);
    pif.mon_valid = 1'b0;
  endtask

  task automatic pulse_scan();
    pif.scan_wrap = 1'b1;
    tick(1);
    pif.scan_wrap = 1'b0;
  endtask

  // Scoreboard monitor: one pop per commit pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && pif.disp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: disp_frame=%0h required no commit", pif.disp_frame);
        end else begin
          e = exp_q.pop_front();
          check("commit_frame", pif.disp_frame, e.frame);
          check("commit_owner", pif.owner, e.owner);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    pif.live_frame = '0;
    pif.live_valid = 1'b0;
    pif.mon_req    = 1'b0;
    pif.mon_frame  = '0;
    pif.mon_valid  = 1'b0;
    pif.scan_wrap  = 1'b0;
    tick(2);
    check("rst_mon_gnt", pif.mon_gnt, 0);
    check("rst_owner", pif.owner, 0);
    check("rst_disp_valid", pif.disp_valid, 0);
    check("rst_disp_frame", pif.disp_frame, 0);
    rst = 1'b0;
    tick(1);

    // First frame commits without hold delay.
    push_exp(101'h1A5, 1'b0);
    pulse_live(101'h1A5);
    tick(2);
    pulse_scan();
    check("first_commit_valid", pif.disp_valid, 1);
    check("first_commit_frame", pif.disp_frame, 101'h1A5);
    tick(1);

    // Early scan_wrap is held off; newest frame commits later.
    pulse_live(101'h222);
    pulse_live(101'h333);
    tick(490);
    pulse_scan();
    check("early_scan_no_commit", pif.disp_valid, 0);
    tick(600);
    push_exp(101'h333, 1'b0);
    pulse_scan();
    check("hold_commit_frame", pif.disp_frame, 101'h333);
    tick(1100);
    pulse_scan();
    check("empty_pend_no_commit", pif.disp_valid, 0);

    // live_valid coinciding with a commit refills the buffer.
    pulse_live(101'h444);
    push_exp(101'h444, 1'b0);
    pif.live_frame = 101'h555;
    pif.live_valid = 1'b1;
    pif.scan_wrap  = 1'b1;
    tick(1);
    pif.live_valid = 1'b0;
    pif.scan_wrap  = 1'b0;
    check("coincide_commit_old", pif.disp_frame, 101'h444);
    tick(1010);
    push_exp(101'h555, 1'b0);
    pulse_scan();
    check("coincide_commit_new", pif.disp_frame, 101'h555);

    // Monitor takeover: pending live frame flushed, switch-state valids ignored.
    tick(1010);
    pulse_live(101'h666);
    pif.mon_req = 1'b1;
    tick(1);
    check("mon_switch_gnt", pif.mon_gnt, 0);
    pulse_mon(101'h777);
    pulse_scan();
    check("mon_gnt_granted", pif.mon_gnt, 1);
    check("mon_owner", pif.owner, 1);
    check("mon_entry_no_commit", pif.disp_valid, 0);
    pulse_scan();
    check("mon_flushed_no_commit", pif.disp_valid, 0);
    pulse_live(101'h888);
    pulse_scan();
    check("nonowner_dropped", pif.disp_valid, 0);
    push_exp(101'h0FF, 1'b1);
    pulse_mon(101'h0FF);
    pulse_scan();
    check("mon_commit_frame", pif.disp_frame, 101'h0FF);
    pif.mon_req = 1'b0;
    tick(1);
    check("release_gnt_drop", pif.mon_gnt, 0);
    pulse_scan();
    check("release_owner_live", pif.owner, 0);

    // Idle timeout revoke and lockout.
    pif.mon_req = 1'b1;
    tick(1);
    pulse_scan();
    check("to_mon_gnt", pif.mon_gnt, 1);
    n = 0;
    while (pif.mon_gnt && n < 200) begin
      tick(1);
      n++;
    end
    check("timeout_in_range", (n >= MON_TIMEOUT && n <= MON_TIMEOUT + 2), 1);
    tick(3);
    pulse_scan();
    check("timeout_owner_live", pif.owner, 0);
    tick(5);
    pulse_scan();
    check("lockout_denies", pif.mon_gnt, 0);
    pif.mon_req = 1'b0;
    tick(1);
    pif.mon_req = 1'b1;
    tick(1);
    pulse_scan();
    check("lockout_cleared_gnt", pif.mon_gnt, 1);

    // Asynchronous reset in MON with a pending frame.
    pulse_mon(101'h999);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_gnt", pif.mon_gnt, 0);
    check("async_rst_owner", pif.owner, 0);
    check("async_rst_frame", pif.disp_frame, 0);
    pif.mon_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);
    pulse_scan();
    check("rst_discard_pend", pif.disp_valid, 0);
    tick(2);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
